load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Translates single core load/store requests into word-aligned bus
// transactions with byte-lane enables. Store data is replicated across the
// lanes. Load data is shifted down from the addressed lane and then sign- or
// zero-extended.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned H/HU/W access is reported as an error and never
//               reaches the bus.
//   undefined : a misaligned access is aligned down to its natural boundary
//               and proceeds. Only an illegal funct3 raises core_err.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   core_valid/we/funct3/addr/wdata
//                        core request; held stable until core_ready
//   core_ready           one-cycle completion pulse
//   core_err             error flag, qualified by core_ready
//   core_rdata           extended load data, qualified by core_ready, else 0
//   bus_req/we/addr/be/wdata
//                        bus request; held stable until bus_gnt
//   bus_gnt              bus accepts the request this cycle
//   bus_rvalid/rdata     read response
// ---------------------------------------------------------------------------
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_valid,
   input  logic        core_we,
   input  logic [2:0]  core_funct3,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        core_ready,
   output logic        core_err,
   output logic [31:0] core_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      ERR
   } state_t;

   state_t      state;
   logic [2:0]  req_funct3;
   logic [1:0]  req_off;

   logic        funct3_bad;
   logic        take_err;
   logic [1:0]  off;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] shifted;
   logic [31:0] load_data;

   // Decode of the live core request. Only consumed in IDLE, where it is
   // captured into registers, so later changes on the core side are ignored.
   // funct3[1:0] gives the access size: 00 byte, 01 half, 10 word.
   always_comb begin
      funct3_bad = (core_funct3 == 3'b011) ||
                   (core_funct3[2:1] == 2'b11) ||
                   (core_we && core_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      take_err = funct3_bad ||
                 ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                 ((core_funct3[1:0] == 2'b10) && (core_addr[1:0] != 2'b00));
`else
      take_err = funct3_bad;
`endif
      off       = 2'b00;
      be        = 4'b1111;
      wdata_rep = core_wdata;
      case (core_funct3[1:0])
         2'b00: begin
            off       = core_addr[1:0];
            be        = 4'b0001 << core_addr[1:0];
            wdata_rep = {4{core_wdata[7:0]}};
         end
         // Halfword offset keeps only a[1], which also aligns a
         // misaligned halfword down when trapping is disabled.
         2'b01: begin
            off       = {core_addr[1], 1'b0};
            be        = 4'b0011 << {core_addr[1], 1'b0};
            wdata_rep = {2{core_wdata[15:0]}};
         end
         default: begin
            off       = 2'b00;
            be        = 4'b1111;
            wdata_rep = core_wdata;
         end
      endcase
   end

   // Load extraction uses only the captured width and lane offset.
   always_comb begin
      shifted = bus_rdata >> {req_off, 3'b000};
      case (req_funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = bus_rdata;
      endcase
   end

   // Control FSM with every output registered. DONE and ERR last exactly
   // one cycle and always fall back to IDLE, so a new request is accepted
   // no earlier than the cycle after the completion pulse. bus_rvalid is
   // only looked at in WAIT, which drops stray responses after a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_funct3 <= 3'b000;
         req_off    <= 2'b00;
         core_ready <= 1'b0;
         core_err   <= 1'b0;
         core_rdata <= 32'd0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'd0;
         bus_be     <= 4'b0000;
         bus_wdata  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (core_valid) begin
                  req_funct3 <= core_funct3;
                  req_off    <= off;
                  if (take_err) begin
                     state      <= ERR;
                     core_ready <= 1'b1;
                     core_err   <= 1'b1;
                     core_rdata <= 32'd0;
                  end else begin
                     state     <= REQ;
                     bus_req   <= 1'b1;
                     bus_we    <= core_we;
                     bus_addr  <= {core_addr[31:2], 2'b00};
                     bus_be    <= be;
                     bus_wdata <= core_we ? wdata_rep : 32'd0;
                  end
               end
            end
            REQ: begin
               if (bus_gnt) begin
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  bus_addr  <= 32'd0;
                  bus_be    <= 4'b0000;
                  bus_wdata <= 32'd0;
                  if (bus_we) begin
                     state      <= DONE;
                     core_ready <= 1'b1;
                     core_err   <= 1'b0;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus_rvalid) begin
                  state      <= DONE;
                  core_ready <= 1'b1;
                  core_err   <= 1'b0;
                  core_rdata <= load_data;
               end
            end
            DONE, ERR: begin
               state      <= IDLE;
               core_ready <= 1'b0;
               core_err   <= 1'b0;
               core_rdata <= 32'd0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. A reference model built from plain
// arithmetic predicts the bus request fields, the completion error flag and
// the extended load data. One compare process checks the DUT against that
// model on every falling edge. A bus responder provides grants and read data
// after a programmable number of cycles. Literal expectations pin the
// latency and the reference vectors. Build with LSU_MISALIGN_TRAP_EN defined
// to cover the trapping variant.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_valid = 1'b0;
   logic        core_we = 1'b0;
   logic [2:0]  core_funct3 = 3'b000;
   logic [31:0] core_addr = 32'd0;
   logic [31:0] core_wdata = 32'd0;
   logic        core_ready;
   logic        core_err;
   logic [31:0] core_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'hDEADBEEF;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_valid  (core_valid),
      .core_we     (core_we),
      .core_funct3 (core_funct3),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_ready  (core_ready),
      .core_err    (core_err),
      .core_rdata  (core_rdata),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_gnt     (bus_gnt),
      .bus_rvalid  (bus_rvalid),
      .bus_rdata   (bus_rdata)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Expectations for the transaction currently in flight
   bit          txn_active = 1'b0;
   bit          exp_bus = 1'b0;
   bit          exp_we = 1'b0;
   bit          exp_err = 1'b0;
   logic [31:0] exp_addr = 32'd0;
   logic [3:0]  exp_be = 4'd0;
   logic [31:0] exp_wdata = 32'd0;
   logic [31:0] exp_rdata = 32'd0;

   // Bus responder settings and state
   int          gnt_delay = 0;
   int          rv_delay = 0;
   logic [31:0] resp_rdata = 32'd0;
   int          req_cnt = 0;
   int          wait_cnt = 0;
   bit          pending_load = 1'b0;

   // Values captured by applyStimulus for the literal checks
   int          lat = 0;
   int          req_cycles = 0;
   logic [31:0] cap_addr = 32'd0;
   logic [3:0]  cap_be = 4'd0;
   logic [31:0] cap_wdata = 32'd0;
   logic        cap_err = 1'b0;
   logic [31:0] cap_rdata = 32'd0;
   bit          prev_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Reference model: access size in bytes, legality, natural alignment,
   // lane mask, lane replication and load extension.
   function automatic int accSize(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit modelErr(input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit bad;
      if (we) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
      else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
      if (!bad && ((a % accSize(f3)) != 0)) bad = 1'b1;
`endif
      return bad;
   endfunction

   function automatic logic [31:0] modelAligned(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] sz;
      sz = 32'(accSize(f3));
      return a - (a % sz);
   endfunction

   function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
      int          sz;
      logic [31:0] aa;
      sz = accSize(f3);
      aa = modelAligned(f3, a);
      return 4'(((1 << sz) - 1) << (aa % 4));
   endfunction

   function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] w);
      case (accSize(f3))
         1:       return (w & 32'hFF) * 32'h01010101;
         2:       return (w & 32'hFFFF) * 32'h00010001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
      longint      v;
      int          bits;
      logic [31:0] aa;
      aa   = modelAligned(f3, a);
      bits = 8 * accSize(f3);
      v    = longint'(word >> (8 * (aa % 4)));
      if (bits < 32) begin
         v = v & ((longint'(1) << bits) - 1);
         if (!f3[2] && (v >= (longint'(1) << (bits - 1)))) v = v - (longint'(1) << bits);
      end
      return 32'(v);
   endfunction

   task automatic setExpect(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rword);
      exp_err   = modelErr(we, f3, a);
      exp_bus   = !exp_err;
      exp_we    = we;
      exp_addr  = modelAligned(f3, a) & ~32'h3;
      exp_be    = modelBe(f3, a);
      exp_wdata = modelWdata(f3, wd);
      exp_rdata = (exp_err || we) ? 32'd0 : modelLoad(f3, a, rword);
   endtask

   // Bus responder: grants after gnt_delay request cycles, then returns
   // read data after rv_delay further cycles for loads.
   always @(negedge clk) begin
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'hDEADBEEF;
      if (!rst_n) begin
         req_cnt = 0;
      end else if (bus_req) begin
         if (req_cnt >= gnt_delay) begin
            bus_gnt      = 1'b1;
            pending_load = !bus_we;
            req_cnt      = 0;
            wait_cnt     = 0;
         end else begin
            req_cnt++;
         end
      end else if (pending_load) begin
         if (wait_cnt >= rv_delay) begin
            bus_rvalid   = 1'b1;
            bus_rdata    = resp_rdata;
            pending_load = 1'b0;
         end else begin
            wait_cnt++;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_req) begin
            if (!exp_bus) begin
               checks++;
               failures++;
               $display("[TB] FAIL bus_req_unexpected actual=1 required=0");
            end else begin
               checkOutput("bus_we", 32'(bus_we), 32'(exp_we));
               checkOutput("bus_addr", bus_addr, exp_addr);
               checkOutput("bus_be", 32'(bus_be), 32'(exp_be));
               if (exp_we) checkOutput("bus_wdata", bus_wdata, exp_wdata);
            end
         end
         if (core_ready) begin
            if (!txn_active) begin
               checks++;
               failures++;
               $display("[TB] FAIL spurious_ready actual=1 required=0");
            end else begin
               checkOutput("core_err", 32'(core_err), 32'(exp_err));
               checkOutput("core_rdata", core_rdata, exp_rdata);
            end
            if (prev_ready) begin
               checks++;
               failures++;
               $display("[TB] FAIL ready_pulse_width actual=2 required=1");
            end
         end else begin
            checkOutput("core_rdata_idle", core_rdata, 32'd0);
         end
         prev_ready = core_ready;
      end else begin
         prev_ready = 1'b0;
      end
   end

   // Runs one full core transaction. lat is measured from the cycle in which
   // core_valid is first presented. With scramble set, the core fields are
   // changed after capture to show they no longer matter.
   task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int gd, input int rd,
                                input logic [31:0] rword, input bit scramble);
      int n;
      bit seen_req;
      gnt_delay  = gd;
      rv_delay   = rd;
      resp_rdata = rword;
      setExpect(we, f3, a, wd, rword);
      @(posedge clk);
      #1;
      core_valid  = 1'b1;
      core_we     = we;
      core_funct3 = f3;
      core_addr   = a;
      core_wdata  = wd;
      txn_active  = 1'b1;
      n           = cyc;
      lat         = -1;
      req_cycles  = 0;
      seen_req    = 1'b0;
      cap_addr    = 32'd0;
      cap_be      = 4'd0;
      cap_wdata   = 32'd0;
      for (int i = 0; i < 60 && lat < 0; i++) begin
         @(negedge clk);
         if (bus_req) begin
            req_cycles++;
            if (!seen_req) begin
               cap_addr  = bus_addr;
               cap_be    = bus_be;
               cap_wdata = bus_wdata;
               seen_req  = 1'b1;
            end
         end
         if (core_ready) begin
            lat       = cyc - n;
            cap_err   = core_err;
            cap_rdata = core_rdata;
         end else if (scramble && cyc > n) begin
            core_addr   = ~a;
            core_funct3 = 3'b010;
            core_wdata  = ~wd;
            core_we     = ~we;
         end
      end
      if (lat < 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_timeout actual=none required=core_ready");
      end
      @(posedge clk);
      #1;
      core_valid  = 1'b0;
      txn_active  = 1'b0;
      core_addr   = 32'hFFFF_FFFF;
      core_wdata  = 32'h5555_5555;
      core_funct3 = 3'b111;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_core_ready"}, 32'(core_ready), 32'd0);
      checkOutput({tag, "_core_err"}, 32'(core_err), 32'd0);
      checkOutput({tag, "_core_rdata"}, core_rdata, 32'd0);
      checkOutput({tag, "_bus_req"}, 32'(bus_req), 32'd0);
      checkOutput({tag, "_bus_we"}, 32'(bus_we), 32'd0);
      checkOutput({tag, "_bus_addr"}, bus_addr, 32'd0);
      checkOutput({tag, "_bus_be"}, 32'(bus_be), 32'd0);
      checkOutput({tag, "_bus_wdata"}, bus_wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ready_cnt;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // SB to the top byte lane
      applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0, 1'b0);
      checkOutput("sb_lat", 32'(lat), 32'd2);
      checkOutput("sb_req_cycles", 32'(req_cycles), 32'd1);
      checkOutput("sb_addr", cap_addr, 32'h0000_1000);
      checkOutput("sb_be", 32'(cap_be), 32'h8);
      checkOutput("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      checkOutput("sb_err", 32'(cap_err), 32'd0);

      // LB and LBU from lane 2
      applyStimulus(1'b0, 3'b000, 32'h0000_2002, 32'd0, 0, 0, 32'h12F4_3456, 1'b0);
      checkOutput("lb_lat", 32'(lat), 32'd3);
      checkOutput("lb_be", 32'(cap_be), 32'h4);
      checkOutput("lb_rdata", cap_rdata, 32'hFFFF_FFF4);
      applyStimulus(1'b0, 3'b100, 32'h0000_2002, 32'd0, 0, 0, 32'h12F4_3456, 1'b0);
      checkOutput("lbu_rdata", cap_rdata, 32'h0000_00F4);

      // LHU with grant held off for three cycles
      applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'd0, 3, 0, 32'h8001_ABCD, 1'b0);
      checkOutput("lhu_req_cycles", 32'(req_cycles), 32'd4);
      checkOutput("lhu_lat", 32'(lat), 32'd6);
      checkOutput("lhu_be", 32'(cap_be), 32'hC);
      checkOutput("lhu_rdata", cap_rdata, 32'h0000_8001);

      // Misaligned LW
      applyStimulus(1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 0, 32'hCAFE_BABE, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("lw_mis_lat", 32'(lat), 32'd1);
      checkOutput("lw_mis_req_cycles", 32'(req_cycles), 32'd0);
      checkOutput("lw_mis_err", 32'(cap_err), 32'd1);
      checkOutput("lw_mis_rdata", cap_rdata, 32'd0);
`else
      checkOutput("lw_mis_lat", 32'(lat), 32'd3);
      checkOutput("lw_mis_addr", cap_addr, 32'h0000_3000);
      checkOutput("lw_mis_be", 32'(cap_be), 32'hF);
      checkOutput("lw_mis_err", 32'(cap_err), 32'd0);
      checkOutput("lw_mis_rdata", cap_rdata, 32'hCAFE_BABE);
`endif

      // Illegal funct3 codes
      applyStimulus(1'b1, 3'b011, 32'h0000_4000, 32'h1111_1111, 0, 0, 32'd0, 1'b0);
      checkOutput("st011_lat", 32'(lat), 32'd1);
      checkOutput("st011_err", 32'(cap_err), 32'd1);
      checkOutput("st011_req_cycles", 32'(req_cycles), 32'd0);
      applyStimulus(1'b0, 3'b110, 32'h0000_4000, 32'd0, 0, 0, 32'h2222_2222, 1'b0);
      checkOutput("ld110_lat", 32'(lat), 32'd1);
      checkOutput("ld110_err", 32'(cap_err), 32'd1);
      applyStimulus(1'b1, 3'b100, 32'h0000_4000, 32'h3333_3333, 0, 0, 32'd0, 1'b0);
      checkOutput("st100_err", 32'(cap_err), 32'd1);

      // SH to upper half, one-cycle grant delay
      applyStimulus(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 1, 0, 32'd0, 1'b0);
      checkOutput("sh_lat", 32'(lat), 32'd3);
      checkOutput("sh_be", 32'(cap_be), 32'hC);
      checkOutput("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

      // LH with late rvalid and core fields changing after capture
      applyStimulus(1'b0, 3'b001, 32'h0000_0000, 32'd0, 0, 2, 32'h0000_8765, 1'b1);
      checkOutput("lh_lat", 32'(lat), 32'd5);
      checkOutput("lh_rdata", cap_rdata, 32'hFFFF_8765);

      // Misaligned SH
      applyStimulus(1'b1, 3'b001, 32'h0000_1001, 32'h0000_CAFE, 0, 0, 32'd0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("sh_mis_err", 32'(cap_err), 32'd1);
      checkOutput("sh_mis_lat", 32'(lat), 32'd1);
`else
      checkOutput("sh_mis_addr", cap_addr, 32'h0000_1000);
      checkOutput("sh_mis_be", 32'(cap_be), 32'h3);
      checkOutput("sh_mis_wdata", cap_wdata, 32'hCAFE_CAFE);
`endif

      // Positive byte from lane 1, full word store
      applyStimulus(1'b0, 3'b000, 32'h0000_5001, 32'd0, 0, 0, 32'h0000_7F00, 1'b0);
      checkOutput("lb_pos_rdata", cap_rdata, 32'h0000_007F);
      applyStimulus(1'b1, 3'b010, 32'h0000_7000, 32'h89AB_CDEF, 0, 0, 32'd0, 1'b0);
      checkOutput("sw_be", 32'(cap_be), 32'hF);
      checkOutput("sw_wdata", cap_wdata, 32'h89AB_CDEF);

      // Reset while the bus request is pending: bus_req drops at once
      gnt_delay = 20;
      setExpect(1'b0, 3'b010, 32'h0000_8000, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      core_valid  = 1'b1;
      core_we     = 1'b0;
      core_funct3 = 3'b010;
      core_addr   = 32'h0000_8000;
      txn_active  = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("pre_rst_bus_req", 32'(bus_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("rst_req");
      core_valid = 1'b0;
      txn_active = 1'b0;
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      gnt_delay = 0;

      // Reset while waiting for read data, followed by a stray rvalid
      rv_delay   = 6;
      resp_rdata = 32'h1122_3344;
      setExpect(1'b0, 3'b010, 32'h0000_9000, 32'd0, 32'h1122_3344);
      @(posedge clk);
      #1;
      core_valid  = 1'b1;
      core_we     = 1'b0;
      core_funct3 = 3'b010;
      core_addr   = 32'h0000_9000;
      txn_active  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("rst_wait");
      core_valid = 1'b0;
      txn_active = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      ready_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (core_ready) ready_cnt++;
      end
      checkOutput("stray_rvalid_ready", 32'(ready_cnt), 32'd0);
      rv_delay = 0;

      // Normal operation after reset
      applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0, 1'b0);
      checkOutput("post_rst_lat", 32'(lat), 32'd2);
      checkOutput("post_rst_wdata", cap_wdata, 32'hA5A5_A5A5);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
